alu_exec_unit: RTL and testbench

- Parametrised successor to the fixed 32-bit ALU top level.
- Holds a NUM_REGS x WIDTH register file and accepts one command per valid/ready handshake.
- For each command it latches operands into the ALU input registers, executes, and writes the result and flags back.
- Any register can be presented to the display driver through a registered readout port.

---
 rtl/alu_exec_unit.sv | 169 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: register-file ALU with valid/ready command intake
// two-state accept/execute sequence and a registered display port
`timescale 1ns/1ps
module alu_exec_unit #(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = 8,
  parameter  int OPW      = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic             err,
  output logic [3:0]       flags,
  input  logic [AW-1:0]    disp_sel,
  output logic [WIDTH-1:0] disp_data
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_AND = 4'd2;
  localparam logic [OPW-1:0] OP_OR  = 4'd3;
  localparam logic [OPW-1:0] OP_XOR = 4'd4;
  localparam logic [OPW-1:0] OP_SLT = 4'd5;
  localparam logic [OPW-1:0] OP_SHL = 4'd6;
  localparam logic [OPW-1:0] OP_SHR = 4'd7;
  localparam logic [OPW-1:0] OP_LDI = 4'd8;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [AW-1:0]    r_rd;
  logic [3:0]       r_flags;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_disp;

  logic [WIDTH-1:0] w_ra_val;
  logic [WIDTH-1:0] w_rb_val;
  logic             w_acc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_y;
  logic             w_c;
  logic             w_o;
  logic             w_upd;
  logic             w_ill;
  logic             w_wr;
  logic [SW-1:0]    w_sh;

  assign w_ra_val  = (cmd_ra == '0) ? '0 : r_regs[cmd_ra];
  assign w_rb_val  = (cmd_rb == '0) ? '0 : r_regs[cmd_rb];
  assign cmd_ready = (r_state == S_IDLE);
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_sh      = r_b[SW-1:0];
  assign w_wr      = !w_ill && (r_rd != '0);

  assign done      = r_done;
  assign err       = r_err;
  assign flags     = r_flags;
  assign disp_data = r_disp;

  // ALU result and flag candidates from the latched operands
  always_comb begin
    w_sum = '0;
    w_y   = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    w_upd = 1'b1;
    w_ill = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_sum = {1'b0, r_a} + {1'b0, r_b};
        w_y   = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_o   = (r_a[M] == r_b[M]) && (w_y[M] != r_a[M]);
      end
      OP_SUB: begin
        w_sum = {1'b0, r_a} + {1'b0, ~r_b}
              + {{WIDTH{1'b0}}, 1'b1};
        w_y   = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_o   = (r_a[M] != r_b[M]) && (w_y[M] != r_a[M]);
      end
      OP_AND: w_y = r_a & r_b;
      OP_OR:  w_y = r_a | r_b;
      OP_XOR: w_y = r_a ^ r_b;
      OP_SLT: w_y = {{(WIDTH-1){1'b0}},
                     ($signed(r_a) < $signed(r_b))};
      OP_SHL: w_y = r_a << w_sh;
      OP_SHR: w_y = r_a >> w_sh;
      OP_LDI: begin
        w_y   = r_b;
        w_upd = 1'b0;
      end
      default: begin
        w_upd = 1'b0;
        w_ill = 1'b1;
      end
    endcase
  end

  // command sequencing, operand latch, flags and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_a     <= w_ra_val;
            r_b     <= (cmd_op == OP_LDI) ? cmd_imm : w_rb_val;
            r_op    <= cmd_op;
            r_rd    <= cmd_rd;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_done <= 1'b1;
          r_err  <= w_ill;
          if (w_upd)
            r_flags <= {w_o, w_c, (w_y == '0), w_y[M]};
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // register file writeback; R0 is never written so it reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (r_state == S_EXEC && w_wr) begin
      r_regs[r_rd] <= w_y;
    end
  end

  // display readout, one cycle behind the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_disp <= '0;
    else
      r_disp <= (disp_sel == '0) ? '0 : r_regs[disp_sel];
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table vectors, random model check,
// back-to-back handshake, reset abort and a 16-bit instance
`timescale 1ns/1ps
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
  logic [31:0] cmd_imm;
  logic        done, err;
  logic [3:0]  flags;
  logic [2:0]  disp_sel;
  logic [31:0] disp_data;

  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [3:0]  s_cmd_op;
  logic [1:0]  s_cmd_rd, s_cmd_ra, s_cmd_rb;
  logic [15:0] s_cmd_imm;
  logic        s_done, s_err;
  logic [3:0]  s_flags;
  logic [1:0]  s_disp_sel;
  logic [15:0] s_disp_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_regs [8];
  logic [3:0]  m_flags;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .NUM_REGS(8), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm),
    .done(done), .err(err), .flags(flags),
    .disp_sel(disp_sel), .disp_data(disp_data)
  );

  alu_exec_unit #(.WIDTH(16), .NUM_REGS(4), .OPW(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(s_cmd_op), .cmd_rd(s_cmd_rd),
    .cmd_ra(s_cmd_ra), .cmd_rb(s_cmd_rb),
    .cmd_imm(s_cmd_imm),
    .done(s_done), .err(s_err), .flags(s_flags),
    .disp_sel(s_disp_sel), .disp_data(s_disp_data)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0;
  endtask

  // architectural reference: plain arithmetic on the register array
  task automatic model(input logic [3:0] op,
                       input logic [2:0] rd, ra, rb,
                       input logic [31:0] imm,
                       output logic e);
    logic [31:0] a, b, y;
    longint sa, sb, sr;
    logic c, o, upd;
    a = m_regs[ra];
    b = m_regs[rb];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    y = '0; c = 0; o = 0; upd = 1; e = 0;
    case (op)
      4'd0: begin
        y = a + b;
        c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
        sr = sa + sb;
        o = (sr > SMAX) || (sr < SMIN);
      end
      4'd1: begin
        y = a - b;
        c = (a >= b);
        sr = sa - sb;
        o = (sr > SMAX) || (sr < SMIN);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: y = a << b[4:0];
      4'd7: y = a >> b[4:0];
      4'd8: begin y = imm; upd = 0; end
      default: begin e = 1; upd = 0; end
    endcase
    if (!e && rd != 0) m_regs[rd] = y;
    if (upd) m_flags = {o, c, (y == 0), y[31]};
  endtask

  // issue one command, check handshake, pulse timing and writeback
  task automatic run_cmd(input logic [3:0] op,
                         input logic [2:0] rd, ra, rb,
                         input logic [31:0] imm);
    logic [31:0] old_v, new_v;
    logic e;
    int n;
    old_v = m_regs[rd];
    model(op, rd, ra, rb, imm, e);
    new_v = m_regs[rd];
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra;
    cmd_rb = rb; cmd_imm = imm; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    disp_sel = rd;
    chk("ready_in_exec", cmd_ready, 0);
    chk("done_early", done, 0);
    @(posedge clk);
    #1;
    chk("done", done, 1);
    chk("err", err, e);
    chk("flags", flags, m_flags);
    chk("disp_old", disp_data, old_v);
    @(posedge clk);
    #1;
    chk("done_pulse_end", done, 0);
    chk("disp_new", disp_data, new_v);
  endtask

  task automatic s_run(input logic [3:0] op,
                       input logic [1:0] rd, ra, rb,
                       input logic [15:0] imm);
    int n;
    @(negedge clk);
    s_cmd_op = op; s_cmd_rd = rd; s_cmd_ra = ra;
    s_cmd_rb = rb; s_cmd_imm = imm; s_cmd_valid = 1'b1;
    n = 0;
    while (!s_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready", s_cmd_ready, 1);
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b0;
    s_disp_sel = rd;
    @(posedge clk);
    #1;
    chk("s_done", s_done, 1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [31:0] imm;
    logic [31:0] exp_val;
    logic [3:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  vec_t tv [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    logic [3:0] b_op [3];
    logic [31:0] b_imm [3];
    int idx, dcnt;
    logic rdy;
    logic seen_done;
    logic [0:5] exp_rdy;

    tv[0]  = '{4'd8, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF,
               32'h7FFF_FFFF, 4'h0, 1'b0};
    tv[1]  = '{4'd8, 3'd2, 3'd0, 3'd0, 32'h1,
               32'h1, 4'h0, 1'b0};
    tv[2]  = '{4'd0, 3'd3, 3'd1, 3'd2, 32'h0,
               32'h8000_0000, 4'b1001, 1'b0};
    tv[3]  = '{4'd8, 3'd4, 3'd0, 3'd0, 32'h5,
               32'h5, 4'b1001, 1'b0};
    tv[4]  = '{4'd1, 3'd5, 3'd4, 3'd4, 32'h0,
               32'h0, 4'b0110, 1'b0};
    tv[5]  = '{4'd5, 3'd6, 3'd1, 3'd3, 32'h0,
               32'h0, 4'b0010, 1'b0};
    tv[6]  = '{4'd8, 3'd0, 3'd0, 3'd0, 32'hFF,
               32'h0, 4'b0010, 1'b0};
    tv[7]  = '{4'd12, 3'd7, 3'd1, 3'd2, 32'h0,
               32'h0, 4'b0010, 1'b1};
    tv[8]  = '{4'd4, 3'd7, 3'd1, 3'd2, 32'h0,
               32'h7FFF_FFFE, 4'b0000, 1'b0};
    tv[9]  = '{4'd7, 3'd7, 3'd3, 3'd2, 32'h0,
               32'h4000_0000, 4'b0000, 1'b0};
    tv[10] = '{4'd6, 3'd6, 3'd2, 3'd4, 32'h0,
               32'h20, 4'b0000, 1'b0};
    tv[11] = '{4'd3, 3'd6, 3'd3, 3'd1, 32'h0,
               32'hFFFF_FFFF, 4'b0001, 1'b0};
    tv[12] = '{4'd2, 3'd6, 3'd3, 3'd1, 32'h0,
               32'h0, 4'b0010, 1'b0};
    tv[13] = '{4'd1, 3'd5, 3'd2, 3'd1, 32'h0,
               32'h8000_0002, 4'b0001, 1'b0};
    tv[14] = '{4'd0, 3'd5, 3'd1, 3'd1, 32'h0,
               32'hFFFF_FFFE, 4'b1001, 1'b0};

    rst_n = 1'b0;
    cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_ra = 0;
    cmd_rb = 0; cmd_imm = 0; disp_sel = 0;
    s_cmd_valid = 0; s_cmd_op = 0; s_cmd_rd = 0; s_cmd_ra = 0;
    s_cmd_rb = 0; s_cmd_imm = 0; s_disp_sel = 0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flags", flags, 0);
    chk("rst_disp", disp_data, 0);

    for (int i = 0; i < 15; i++) begin
      run_cmd(tv[i].op, tv[i].rd, tv[i].ra,
              tv[i].rb, tv[i].imm);
      chk($sformatf("vec%0d_val", i), disp_data, tv[i].exp_val);
      chk($sformatf("vec%0d_flags", i), flags, tv[i].exp_flags);
      chk($sformatf("vec%0d_err", i), err, 1'b0);
    end

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'd8;
      run_cmd(op, 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), $urandom);
    end

    // cmd_valid held high across three commands
    b_op[0] = 4'd8; b_imm[0] = 32'd11;
    b_op[1] = 4'd0; b_imm[1] = 32'd0;
    b_op[2] = 4'd0; b_imm[2] = 32'd0;
    exp_rdy = 6'b101010;
    for (int k = 0; k < 3; k++)
      model(b_op[k], 3'd1, 3'd1, 3'd1, b_imm[k], e);
    @(negedge clk);
    idx = 0; dcnt = 0;
    cmd_op = b_op[0]; cmd_imm = b_imm[0];
    cmd_rd = 3'd1; cmd_ra = 3'd1; cmd_rb = 3'd1;
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      rdy = cmd_ready;
      if (done) dcnt++;
      if (cyc < 6) chk($sformatf("b2b_ready%0d", cyc), rdy, exp_rdy[cyc]);
      @(posedge clk);
      if (rdy && cmd_valid) idx++;
      #1;
      if (idx < 3) begin
        cmd_op = b_op[idx]; cmd_imm = b_imm[idx];
      end else begin
        cmd_valid = 1'b0;
      end
    end
    chk("b2b_done_count", dcnt, 3);
    chk("b2b_accepts", idx, 3);
    disp_sel = 3'd1;
    @(posedge clk);
    #1;
    chk("b2b_r1", disp_data, m_regs[1]);
    chk("b2b_r1_val", disp_data, 32'd44);
    chk("b2b_flags", flags, m_flags);

    // reset asserted while the ADD is executing
    @(negedge clk);
    cmd_op = 4'd0; cmd_rd = 3'd6; cmd_ra = 3'd1; cmd_rb = 3'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("abort_in_exec", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready_rst", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    seen_done = 1'b0;
    disp_sel = 3'd6;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_r6", disp_data, 0);
    chk("abort_flags", flags, 0);
    run_cmd(4'd8, 3'd2, 3'd0, 3'd0, 32'h1234);

    // 16-bit, 4-register instance
    s_run(4'd8, 2'd1, 2'd0, 2'd0, 16'h8001);
    chk("s_ldi", s_disp_data, 16'h8001);
    s_run(4'd8, 2'd2, 2'd0, 2'd0, 16'h0001);
    s_run(4'd6, 2'd3, 2'd1, 2'd2, 16'h0);
    chk("s_shl", s_disp_data, 16'h0002);
    chk("s_shl_flags", s_flags, 4'b0000);
    s_run(4'd0, 2'd3, 2'd1, 2'd1, 16'h0);
    chk("s_add", s_disp_data, 16'h0002);
    chk("s_add_flags", s_flags, 4'b1100);
    s_run(4'd15, 2'd3, 2'd1, 2'd1, 16'h0);
    chk("s_ill_err", s_err, 1'b0);
    chk("s_ill_keep", s_disp_data, 16'h0002);
    chk("s_ill_flags", s_flags, 4'b1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
